usr_shift_sequencer: RTL and testbench

- Command-driven sequencer for the team's 8-bit universal shift register.
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's mode and parallel-data inputs cycle by cycle, counts shift steps and presents the bit shifted out each cycle.
- Pulses done with a captured result. Sits between a byte-level producer (e.g. a UART/SPI TX front end) and the shift-register datapath.

---
 rtl/usr_seq_pkg.sv | 47 ++++
 rtl/usr_step_counter.sv | 70 +++++++
 rtl/usr_shift_sequencer.sv | 176 +++++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_seq_pkg.sv
// Shared definitions for the universal shift register sequencer.
// Holds the register mode encoding, the command opcodes, the FSM
// state encoding and small decode helpers used by the sequencer.
package usr_seq_pkg;

    // Mode codes understood by the universal shift register.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command opcodes accepted on cmd_op.
    localparam logic [1:0] OP_LOAD = 2'b00;  // parallel load only
    localparam logic [1:0] OP_SHR  = 2'b01;  // shift right N
    localparam logic [1:0] OP_SHL  = 2'b10;  // shift left N
    localparam logic [1:0] OP_SER  = 2'b11;  // load, then shift right N

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

    // Opcodes that begin with a parallel load cycle.
    function automatic logic op_has_load(input logic [1:0] op);
        logic res;
        if ((op == OP_LOAD) || (op == OP_SER)) begin
            res = 1'b1;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    // Register mode used during the shift phase of an opcode.
    function automatic logic [1:0] op_shift_mode(input logic [1:0] op);
        logic [1:0] res;
        if (op == OP_SHL) begin
            res = MODE_SHL;
        end else begin
            res = MODE_SHR;
        end
        return res;
    endfunction

endpackage

// File: rtl/usr_step_counter.sv
// Loadable down-counter that tracks remaining shift steps.
// The load value is clamped to WIDTH so a shift never runs longer than
// the register is wide; the counter stops at zero.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - capture load_val (clamped) as the new count
//   load_val    - requested number of steps
//   dec         - consume one step
//   last        - registered flag: exactly one step remains
//   zero        - registered flag: no steps remain
module usr_step_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last,
    output logic             zero
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] sat_s;
    logic [CNT_W-1:0] next_s;
    logic             last_r;
    logic             zero_r;

    // Clamp requested step count to the register width.
    always_comb begin
        sat_s = load_val;
        if (load_val > MAX_CNT) begin
            sat_s = MAX_CNT;
        end else begin
            sat_s = load_val;
        end
    end

    // Next count: load wins over decrement; never wrap below zero.
    always_comb begin
        next_s = count_r;
        if (load) begin
            next_s = sat_s;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            next_s = count_r - CNT_W'(1);
        end else begin
            next_s = count_r;
        end
    end

    // Count register plus flags computed from the next value so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            last_r  <= 1'b0;
            zero_r  <= 1'b1;
        end else begin
            count_r <= next_s;
            last_r  <= (next_s == CNT_W'(1));
            zero_r  <= (next_s == {CNT_W{1'b0}});
        end
    end

    assign last = last_r;
    assign zero = zero_r;

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer for the 8-bit universal shift register.
// Takes one command at a time on a valid/ready handshake, drives the
// register mode and parallel input cycle by cycle, presents the bit
// leaving the register during shifts and pulses done with the captured
// register contents.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_op/data/count     - opcode, load value, shift step count
//   ser_in                - fill bit for shifts
//   sr_mode/sr_datain     - control and parallel data to the register
//   sr_dataout            - register contents
//   ser_out/ser_valid     - bit shifted out this cycle and its qualifier
//   busy/done/result      - status, completion pulse, captured contents
module usr_shift_sequencer
    import usr_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             ser_in,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_datain,
    input  logic [WIDTH-1:0] sr_dataout,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    seq_state_e       state_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] result_r;
    logic             ready_en_r;

    logic             accept_s;
    logic             dec_s;
    logic             cnt_last_s;
    logic             cnt_zero_s;
    logic             cmd_ready_s;
    logic [1:0]       sr_mode_s;
    logic [WIDTH-1:0] sr_datain_s;
    logic             ser_out_s;
    logic             ser_valid_s;
    logic             busy_s;
    logic             done_s;

    // ready_en_r keeps cmd_ready low while reset is held and for the
    // release cycle, so no command can slip in during reset recovery.
    assign cmd_ready_s = (state_r == ST_IDLE) && ready_en_r;
    assign accept_s    = cmd_valid && cmd_ready_s;
    assign dec_s       = (state_r == ST_SHIFT);

    usr_step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk      (clk),
        .rst_n    (reset),
        .load     (accept_s),
        .load_val (cmd_count),
        .dec      (dec_s),
        .last     (cnt_last_s),
        .zero     (cnt_zero_s)
    );

    // Sequencer FSM with latched command fields and the result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_LOAD;
            data_r     <= {WIDTH{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= cmd_op;
                        data_r <= cmd_data;
                        if (op_has_load(cmd_op)) begin
                            state_r <= ST_LOAD;
                        end else if (cmd_count == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if ((op_r == OP_LOAD) || cnt_zero_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_last_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    result_r <= sr_dataout;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode of state and latched fields onto the register controls.
    always_comb begin
        sr_mode_s   = MODE_HOLD;
        sr_datain_s = {WIDTH{1'b0}};
        ser_out_s   = 1'b0;
        ser_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sr_mode_s = MODE_HOLD;
            end
            ST_LOAD: begin
                sr_mode_s   = MODE_LOAD;
                sr_datain_s = data_r;
                busy_s      = 1'b1;
            end
            ST_SHIFT: begin
                sr_mode_s   = op_shift_mode(op_r);
                sr_datain_s = {WIDTH{ser_in}};
                ser_valid_s = 1'b1;
                busy_s      = 1'b1;
                // The bit leaving is the one at the trailing end of the shift.
                if (op_r == OP_SHL) begin
                    ser_out_s = sr_dataout[WIDTH-1];
                end else begin
                    ser_out_s = sr_dataout[0];
                end
            end
            ST_DONE: begin
                sr_mode_s = MODE_HOLD;
                busy_s    = 1'b1;
                done_s    = 1'b1;
            end
            default: begin
                sr_mode_s = MODE_HOLD;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_s;
    assign sr_mode   = sr_mode_s;
    assign sr_datain = sr_datain_s;
    assign ser_out   = ser_out_s;
    assign ser_valid = ser_valid_s;
    assign busy      = busy_s;
    assign done      = done_s;
    assign result    = result_r;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a behavioural universal
// shift register closing the loop and a scoreboard of expected serial
// bits and results.
module tb_usr_shift_sequencer;
    import usr_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = 8'h00;
    logic [CNT_W-1:0] cmd_count = 4'h0;
    logic             ser_in = 1'b0;
    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_datain;
    logic [WIDTH-1:0] sr_dataout;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] sr_q = 8'h00;
    logic             ser_q[$];
    logic [WIDTH-1:0] res_q[$];
    int               tests = 0;
    int               fails = 0;

    always #5 clk = ~clk;

    usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .ser_in     (ser_in),
        .sr_mode    (sr_mode),
        .sr_datain  (sr_datain),
        .sr_dataout (sr_dataout),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // Behavioural universal shift register driven by the sequencer.
    always @(posedge clk) begin
        case (sr_mode)
            MODE_SHR:  sr_q <= {sr_datain[WIDTH-1], sr_q[WIDTH-1:1]};
            MODE_SHL:  sr_q <= {sr_q[WIDTH-2:0], sr_datain[0]};
            MODE_LOAD: sr_q <= sr_datain;
            default:   sr_q <= sr_q;
        endcase
    end
    assign sr_dataout = sr_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, follow it to completion and score everything it produces.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                           input logic [3:0] cnt, input logic fill);
        logic [7:0] reg_v;
        int         n;
        int         lat;
        int         n_shift;
        int         n_load;
        int         exp_load;
        logic       seen_done;
        logic [1:0] shmode;

        n = (int'(cnt) > WIDTH) ? WIDTH : int'(cnt);
        reg_v = sr_q;
        if (op == OP_LOAD || op == OP_SER) reg_v = data;
        if (op == OP_LOAD) n = 0;
        shmode = (op == OP_SHL) ? MODE_SHL : MODE_SHR;
        for (int i = 0; i < n; i++) begin
            if (op == OP_SHL) begin
                ser_q.push_back(reg_v[7]);
                reg_v = {reg_v[6:0], fill};
            end else begin
                ser_q.push_back(reg_v[0]);
                reg_v = {fill, reg_v[7:1]};
            end
        end
        res_q.push_back(reg_v);
        if (op == OP_LOAD)     lat = 2;
        else if (op == OP_SER) lat = n + 2;
        else                   lat = n + 1;
        exp_load = (op == OP_LOAD || op == OP_SER) ? 1 : 0;

        for (int w = 0; w < 20 && cmd_ready !== 1'b1; w++) @(negedge clk);
        check({tag, " ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt; ser_in = fill;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = ~data; cmd_count = 4'hF;

        n_shift = 0; n_load = 0; seen_done = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (sr_mode == MODE_LOAD) begin
                n_load++;
                check({tag, " load_data"}, 32'(sr_datain), 32'(data));
            end
            if ((op == OP_SHR || op == OP_SHL) && n == 0)
                check({tag, " mode_hold"}, 32'(sr_mode), 32'(MODE_HOLD));
            if (ser_valid) begin
                n_shift++;
                check({tag, " shift_mode"}, 32'(sr_mode), 32'(shmode));
                check({tag, " shift_fill"}, 32'(sr_datain), 32'({WIDTH{fill}}));
                if (ser_q.size() == 0) check({tag, " extra_ser_bit"}, 32'd1, 32'd0);
                else                   check({tag, " ser_out"}, 32'(ser_out), 32'(ser_q.pop_front()));
            end
            if (done) begin
                check({tag, " latency"}, 32'(cyc), 32'(lat));
                check({tag, " busy_in_done"}, 32'(busy), 32'd1);
                check({tag, " ready_in_done"}, 32'(cmd_ready), 32'd0);
                seen_done = 1'b1;
                break;
            end
        end
        if (!seen_done) check({tag, " done_timeout"}, 32'd0, 32'd1);
        check({tag, " shift_cycles"}, 32'(n_shift), 32'(n));
        check({tag, " load_cycles"}, 32'(n_load), 32'(exp_load));
        check({tag, " ser_left"}, 32'(ser_q.size()), 32'd0);
        ser_q.delete();
        @(negedge clk);
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " ready_after"}, 32'(cmd_ready), 32'd1);
        if (res_q.size() == 0) check({tag, " result_missing"}, 32'd1, 32'd0);
        else                   check({tag, " result"}, 32'(result), 32'(res_q.pop_front()));
    endtask

    initial begin
        int accepted;
        int ndone;
        logic chk_res;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst sr_mode", 32'(sr_mode), 32'd0);
        check("rst sr_datain", 32'(sr_datain), 32'd0);
        check("rst ser_valid", 32'(ser_valid), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst result", 32'(result), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst ready_after_release", 32'(cmd_ready), 32'd1);

        run_cmd("load0C", OP_LOAD, 8'h0C, 4'd0, 1'b0);

        // Reset in the middle of a serialize command.
        cmd_valid = 1'b1; cmd_op = OP_SER; cmd_data = 8'h5A; cmd_count = 4'd8; ser_in = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst in_shift", 32'(ser_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst sr_mode", 32'(sr_mode), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ser_valid", 32'(ser_valid), 32'd0);
        check("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst ready_after", 32'(cmd_ready), 32'd1);
        check("midrst result", 32'(result), 32'd0);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst no_done", 32'(ndone), 32'd0);

        run_cmd("serA5", OP_SER, 8'hA5, 4'd8, 1'b0);
        run_cmd("load0E", OP_LOAD, 8'h0E, 4'd0, 1'b0);
        run_cmd("shl3", OP_SHL, 8'h00, 4'd3, 1'b1);
        check("shl3 value", 32'(result), 32'h77);
        run_cmd("shr0", OP_SHR, 8'h00, 4'd0, 1'b0);
        run_cmd("ser_sat12", OP_SER, 8'h3C, 4'd12, 1'b1);
        run_cmd("shr4", OP_SHR, 8'h00, 4'd4, 1'b0);

        // cmd_valid held high with data changing every cycle.
        cmd_op = OP_LOAD; cmd_count = 4'd0;
        accepted = 0; ndone = 0; chk_res = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (chk_res) begin
                if (res_q.size() == 0) check("hs result_missing", 32'd1, 32'd0);
                else                   check("hs result", 32'(result), 32'(res_q.pop_front()));
                chk_res = 1'b0;
            end
            if (done) begin ndone++; chk_res = 1'b1; end
            if (busy) check("hs ready_while_busy", 32'(cmd_ready), 32'd0);
            cmd_data = 8'(c * 37 + 5);
            cmd_valid = 1'b1;
            if (cmd_ready) begin res_q.push_back(cmd_data); accepted++; end
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (chk_res) begin
                if (res_q.size() == 0) check("hs result_missing", 32'd1, 32'd0);
                else                   check("hs result", 32'(result), 32'(res_q.pop_front()));
                chk_res = 1'b0;
            end
            if (done) begin ndone++; chk_res = 1'b1; end
        end
        check("hs accepted", 32'(accepted), 32'd10);
        check("hs done_per_cmd", 32'(ndone), 32'(accepted));
        check("hs results_left", 32'(res_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
